issue_ctrl: RTL and testbench

Issue controller between the instruction decoder and the ALU/execute stage. It holds one decoded instruction in a registered issue slot and tracks pending register writes in a 32-entry scoreboard. It stalls on RAW/WAW hazards, drops illegal instructions with a one-cycle exception pulse, and releases scoreboard entries on writeback.

---
 rtl/issue_ctrl_pkg.sv | 12 +
 rtl/issue_ctrl_if.sv | 44 ++++
 rtl/issue_ctrl_scoreboard.sv | 43 ++++
 rtl/issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared types and defaults for the issue controller: slot state encoding and width defaults.
package issue_ctrl_pkg;

  localparam int RF_AW_DEF     = 5;
  localparam int PAYLOAD_W_DEF = 48;

  typedef enum logic {
    ISSUE_ST_EMPTY = 1'b0,
    ISSUE_ST_HELD  = 1'b1
  } issue_st_e;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decoder -> issue -> execute handshake bundle, plus writeback, flush and the illegal-instruction pulse.
interface issue_ctrl_if #(
  parameter int RF_AW     = 5,
  parameter int PAYLOAD_W = 48
) ();

  logic                 dec_valid;
  logic                 dec_ready;
  logic                 dec_reg_wen;
  logic [RF_AW-1:0]     dec_waddr;
  logic [RF_AW-1:0]     dec_rs1_addr;
  logic [RF_AW-1:0]     dec_rs2_addr;
  logic                 dec_rs1_used;
  logic                 dec_rs2_used;
  logic                 dec_ill_instr;
  logic [PAYLOAD_W-1:0] dec_payload;

  logic                 iss_valid;
  logic                 iss_ready;
  logic                 iss_reg_wen;
  logic [RF_AW-1:0]     iss_waddr;
  logic [PAYLOAD_W-1:0] iss_payload;

  logic                 wb_valid;
  logic [RF_AW-1:0]     wb_addr;
  logic                 flush;
  logic                 ill_exc;

  // Environment side: decoder, execute stage and writeback drive the inputs.
  modport master (
    output dec_valid, dec_reg_wen, dec_waddr, dec_rs1_addr, dec_rs2_addr,
           dec_rs1_used, dec_rs2_used, dec_ill_instr, dec_payload,
           iss_ready, wb_valid, wb_addr, flush,
    input  dec_ready, iss_valid, iss_reg_wen, iss_waddr, iss_payload, ill_exc
  );

  modport slave (
    input  dec_valid, dec_reg_wen, dec_waddr, dec_rs1_addr, dec_rs2_addr,
           dec_rs1_used, dec_rs2_used, dec_ill_instr, dec_payload,
           iss_ready, wb_valid, wb_addr, flush,
    output dec_ready, iss_valid, iss_reg_wen, iss_waddr, iss_payload, ill_exc
  );

endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 tied to 0.
// Reads see a same-cycle writeback as already retired; a same-cycle set beats a clear.
module issue_ctrl_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int RF_AW = RF_AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en_i,
  input  logic [RF_AW-1:0] set_addr_i,
  input  logic             clr_en_i,
  input  logic [RF_AW-1:0] clr_addr_i,
  input  logic [RF_AW-1:0] rs1_addr_i,
  input  logic [RF_AW-1:0] rs2_addr_i,
  input  logic [RF_AW-1:0] rd_addr_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic             rd_busy_o
);

  localparam int NREG = 1 << RF_AW;

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) sb_d[clr_addr_i] = 1'b0;
    if (set_en_i) sb_d[set_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  assign rs1_busy_o = sb_q[rs1_addr_i] & ~(clr_en_i & (clr_addr_i == rs1_addr_i));
  assign rs2_busy_o = sb_q[rs2_addr_i] & ~(clr_en_i & (clr_addr_i == rs2_addr_i));
  assign rd_busy_o  = sb_q[rd_addr_i]  & ~(clr_en_i & (clr_addr_i == rd_addr_i));

endmodule

// File: rtl/issue_ctrl.sv
// Single-slot issue stage with RAW/WAW scoreboard stall, illegal-instruction drop and flush.
// Optional ISSUE_CTRL_PERF_EN adds stall_cnt/issue_cnt performance counters.
//
// state          | meaning
// ISSUE_ST_EMPTY | slot free, decoder may write it
// ISSUE_ST_HELD  | slot holds a decoded instruction waiting to issue or drop
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int RF_AW     = RF_AW_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  issue_ctrl_if.slave bus
`ifdef ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] issue_cnt
`endif
);

  issue_st_e            state_q, state_d;
  logic                 reg_wen_q, reg_wen_d;
  logic [RF_AW-1:0]     waddr_q, waddr_d;
  logic [RF_AW-1:0]     rs1_q, rs1_d;
  logic [RF_AW-1:0]     rs2_q, rs2_d;
  logic                 rs1_used_q, rs1_used_d;
  logic                 rs2_used_q, rs2_used_d;
  logic                 ill_q, ill_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  logic held;
  logic rs1_busy, rs2_busy, rd_busy;
  logic hazard;
  logic iss_valid_w;
  logic fire;
  logic ill_drop;
  logic dec_ready_w;
  logic accept;

  assign held        = (state_q == ISSUE_ST_HELD);
  assign hazard      = (rs1_used_q & rs1_busy) | (rs2_used_q & rs2_busy) | (reg_wen_q & rd_busy);
  assign iss_valid_w = held & ~ill_q & ~hazard & ~bus.flush;
  assign fire        = iss_valid_w & bus.iss_ready;
  // An illegal entry leaves regardless of hazards or execute backpressure.
  assign ill_drop    = held & ill_q & ~bus.flush;
  assign dec_ready_w = (~held | fire | ill_drop) & ~bus.flush;
  assign accept      = bus.dec_valid & dec_ready_w;

  issue_ctrl_scoreboard #(
    .RF_AW (RF_AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (fire & reg_wen_q & (waddr_q != '0)),
    .set_addr_i (waddr_q),
    .clr_en_i   (bus.wb_valid),
    .clr_addr_i (bus.wb_addr),
    .rs1_addr_i (rs1_q),
    .rs2_addr_i (rs2_q),
    .rd_addr_i  (waddr_q),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_busy_o  (rd_busy)
  );

  always_comb begin
    state_d    = state_q;
    reg_wen_d  = reg_wen_q;
    waddr_d    = waddr_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1_used_d = rs1_used_q;
    rs2_used_d = rs2_used_q;
    ill_d      = ill_q;
    payload_d  = payload_q;
    if (accept) begin
      state_d    = ISSUE_ST_HELD;
      reg_wen_d  = bus.dec_reg_wen;
      waddr_d    = bus.dec_waddr;
      rs1_d      = bus.dec_rs1_addr;
      rs2_d      = bus.dec_rs2_addr;
      rs1_used_d = bus.dec_rs1_used;
      rs2_used_d = bus.dec_rs2_used;
      ill_d      = bus.dec_ill_instr;
      payload_d  = bus.dec_payload;
    end else if (fire | ill_drop | bus.flush) begin
      state_d = ISSUE_ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ISSUE_ST_EMPTY;
      reg_wen_q  <= 1'b0;
      waddr_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_used_q <= 1'b0;
      rs2_used_q <= 1'b0;
      ill_q      <= 1'b0;
      payload_q  <= '0;
    end else begin
      state_q    <= state_d;
      reg_wen_q  <= reg_wen_d;
      waddr_q    <= waddr_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_used_q <= rs1_used_d;
      rs2_used_q <= rs2_used_d;
      ill_q      <= ill_d;
      payload_q  <= payload_d;
    end
  end

  assign bus.dec_ready   = dec_ready_w;
  assign bus.iss_valid   = iss_valid_w;
  assign bus.iss_reg_wen = reg_wen_q;
  assign bus.iss_waddr   = waddr_q;
  assign bus.iss_payload = payload_q;
  assign bus.ill_exc     = ill_drop;

`ifdef ISSUE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] issue_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      if (held & (hazard | ~bus.iss_ready)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (fire)                             issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl with a cycle-level reference model of slot and pending-write set.
module tb_issue_ctrl;

  localparam int AW = 5;
  localparam int PW = 48;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  issue_ctrl_if #(.RF_AW(AW), .PAYLOAD_W(PW)) bus ();

`ifdef ISSUE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] issue_cnt;
`endif

  issue_ctrl #(.RF_AW(AW), .PAYLOAD_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef ISSUE_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .issue_cnt (issue_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which registers have writes outstanding, and what the slot holds.
  bit          m_pend[32];
  bit          m_held;
  bit          m_wen, m_ill, m_u1, m_u2;
  bit [AW-1:0] m_rd, m_rs1, m_rs2;
  bit [PW-1:0] m_pay;
  bit [31:0]   m_stall, m_issue;

  function automatic bit still_pending(input bit [AW-1:0] r);
    if (r == 0) return 1'b0;
    if (bus.wb_valid && bus.wb_addr == r) return 1'b0;
    return m_pend[r];
  endfunction

  always @(negedge clk) begin
    bit haz, e_valid, e_fire, e_drop, e_ready;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_held = 0; m_wen = 0; m_ill = 0; m_u1 = 0; m_u2 = 0;
      m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_pay = 0;
      m_stall = 0; m_issue = 0;
    end
    haz     = (m_u1 && still_pending(m_rs1)) || (m_u2 && still_pending(m_rs2)) ||
              (m_wen && still_pending(m_rd));
    e_valid = m_held && !m_ill && !haz && !bus.flush;
    e_fire  = e_valid && bus.iss_ready;
    e_drop  = m_held && m_ill && !bus.flush;
    e_ready = (!m_held || e_fire || e_drop) && !bus.flush;
    chk("m_iss_valid", 64'(bus.iss_valid), 64'(e_valid));
    chk("m_ill_exc", 64'(bus.ill_exc), 64'(e_drop));
    if (!rst) chk("m_dec_ready", 64'(bus.dec_ready), 64'(e_ready));
    chk("m_iss_reg_wen", 64'(bus.iss_reg_wen), 64'(m_wen));
    chk("m_iss_waddr", 64'(bus.iss_waddr), 64'(m_rd));
    chk("m_iss_payload", 64'(bus.iss_payload), 64'(m_pay));
`ifdef ISSUE_CTRL_PERF_EN
    chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("m_issue_cnt", 64'(issue_cnt), 64'(m_issue));
`endif
    if (!rst) begin
      if (m_held && (haz || !bus.iss_ready)) m_stall++;
      if (e_fire) m_issue++;
      if (bus.wb_valid) m_pend[bus.wb_addr] = 1'b0;
      if (e_fire && m_wen && m_rd != 0) m_pend[m_rd] = 1'b1;
      if (bus.dec_valid && e_ready) begin
        m_held = 1; m_wen = bus.dec_reg_wen; m_rd = bus.dec_waddr;
        m_rs1 = bus.dec_rs1_addr; m_rs2 = bus.dec_rs2_addr;
        m_u1 = bus.dec_rs1_used; m_u2 = bus.dec_rs2_used;
        m_ill = bus.dec_ill_instr; m_pay = bus.dec_payload;
      end else if (e_fire || e_drop || bus.flush) begin
        m_held = 0;
      end
    end
  end

  task automatic idle_in();
    bus.dec_valid = 0; bus.dec_reg_wen = 0; bus.dec_waddr = 0;
    bus.dec_rs1_addr = 0; bus.dec_rs2_addr = 0;
    bus.dec_rs1_used = 0; bus.dec_rs2_used = 0;
    bus.dec_ill_instr = 0; bus.dec_payload = 0;
    bus.iss_ready = 1; bus.wb_valid = 0; bus.wb_addr = 0; bus.flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input bit wen, input int rd, input int rs1, input bit u1,
                       input int rs2, input bit u2, input bit ill, input logic [PW-1:0] pay);
    bus.dec_valid = 1; bus.dec_reg_wen = wen; bus.dec_waddr = AW'(rd);
    bus.dec_rs1_addr = AW'(rs1); bus.dec_rs1_used = u1;
    bus.dec_rs2_addr = AW'(rs2); bus.dec_rs2_used = u2;
    bus.dec_ill_instr = ill; bus.dec_payload = pay;
  endtask

  initial begin
    rst = 1;
    idle_in();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // A: writes x5, reads x1; accepted now, visible next cycle.
    instr(1, 5, 1, 1, 0, 0, 0, 48'h0000_00A5_0001);
    @(negedge clk); chk("a_dec_ready", 64'(bus.dec_ready), 64'd1);
    chk("a_not_yet_valid", 64'(bus.iss_valid), 64'd0);
    cyc(); idle_in();
    @(negedge clk); chk("a_iss_valid", 64'(bus.iss_valid), 64'd1);
    chk("a_iss_waddr", 64'(bus.iss_waddr), 64'd5);
    chk("a_iss_payload", 64'(bus.iss_payload), 64'h0000_00A5_0001);
    cyc();

    // B reads x5 (RAW) and stalls until writeback of x5 bypasses.
    instr(1, 6, 5, 1, 0, 0, 0, 48'h0000_00B0_0002);
    cyc(); idle_in();
    @(negedge clk); chk("b_raw_stall", 64'(bus.iss_valid), 64'd0);
    chk("b_dec_ready_held", 64'(bus.dec_ready), 64'd0);
    cyc();
    @(negedge clk); chk("b_raw_stall2", 64'(bus.iss_valid), 64'd0);
    cyc(); bus.wb_valid = 1; bus.wb_addr = 5;
    @(negedge clk); chk("b_wb_bypass", 64'(bus.iss_valid), 64'd1);
    chk("b_iss_waddr", 64'(bus.iss_waddr), 64'd6);
    cyc(); idle_in();

    // Illegal with execute not ready: one-cycle pulse, replaced by C in the same cycle.
    instr(1, 7, 0, 0, 0, 0, 1, 48'h0000_0BAD_0003);
    bus.iss_ready = 0;
    cyc(); idle_in(); bus.iss_ready = 0;
    instr(1, 8, 7, 1, 0, 0, 0, 48'h0000_00C0_0004);
    @(negedge clk); chk("ill_exc_pulse", 64'(bus.ill_exc), 64'd1);
    chk("ill_no_issue", 64'(bus.iss_valid), 64'd0);
    chk("ill_dec_ready", 64'(bus.dec_ready), 64'd1);
    cyc(); idle_in();
    @(negedge clk); chk("ill_exc_gone", 64'(bus.ill_exc), 64'd0);
    chk("c_after_ill_valid", 64'(bus.iss_valid), 64'd1);
    chk("c_after_ill_waddr", 64'(bus.iss_waddr), 64'd8);
    cyc();

    // x0 as destination and sources with a writeback to x0 in flight.
    instr(1, 0, 0, 1, 0, 1, 0, 48'h0000_00D0_0005);
    bus.wb_valid = 1; bus.wb_addr = 0;
    cyc(); idle_in();
    instr(0, 0, 0, 1, 0, 1, 0, 48'h0000_00D1_0006);
    @(negedge clk); chk("x0_no_stall", 64'(bus.iss_valid), 64'd1);
    cyc(); idle_in();
    @(negedge clk); chk("x0_never_set", 64'(bus.iss_valid), 64'd1);
    cyc();

    // Flush a hazard-stalled entry; x6 must remain pending afterwards.
    instr(1, 10, 6, 1, 0, 0, 0, 48'h0000_00E0_0007);
    cyc(); idle_in();
    @(negedge clk); chk("e_stall", 64'(bus.iss_valid), 64'd0);
    cyc(); bus.flush = 1;
    instr(1, 11, 0, 0, 0, 0, 0, 48'h0000_00E1_0008);
    @(negedge clk); chk("flush_dec_ready", 64'(bus.dec_ready), 64'd0);
    cyc(); idle_in();
    @(negedge clk); chk("flush_empty_valid", 64'(bus.iss_valid), 64'd0);
    chk("flush_empty_ready", 64'(bus.dec_ready), 64'd1);
    instr(1, 6, 0, 0, 0, 0, 0, 48'h0000_00F0_0009);
    cyc(); idle_in();
    @(negedge clk); chk("f_waw_stall", 64'(bus.iss_valid), 64'd0);
    cyc(); bus.wb_valid = 1; bus.wb_addr = 6;
    @(negedge clk); chk("f_waw_bypass", 64'(bus.iss_valid), 64'd1);
    cyc(); idle_in();

    // Set wins over same-cycle clear: x6 is pending again for G's rs2.
    instr(0, 0, 0, 0, 6, 1, 0, 48'h0000_0060_000A);
    cyc(); idle_in();
    @(negedge clk); chk("g_set_wins_stall", 64'(bus.iss_valid), 64'd0);
    cyc(); bus.wb_valid = 1; bus.wb_addr = 6;
    @(negedge clk); chk("g_issue", 64'(bus.iss_valid), 64'd1);
    cyc(); idle_in();

    // Unused rs2 pointing at pending x8 must not stall.
    instr(0, 0, 0, 0, 8, 0, 0, 48'h0000_0080_000B);
    cyc(); idle_in();
    @(negedge clk); chk("h_rs2_unused", 64'(bus.iss_valid), 64'd1);
    cyc();

    // Backpressure holds outputs stable, then back-to-back issue.
    bus.iss_ready = 0;
    instr(1, 12, 0, 0, 0, 0, 0, 48'h0000_0120_000C);
    cyc(); bus.iss_ready = 0;
    instr(1, 13, 0, 0, 0, 0, 0, 48'h0000_0130_000D);
    @(negedge clk); chk("bp_valid", 64'(bus.iss_valid), 64'd1);
    chk("bp_waddr", 64'(bus.iss_waddr), 64'd12);
    chk("bp_dec_ready", 64'(bus.dec_ready), 64'd0);
    cyc();
    @(negedge clk); chk("bp_payload_stable", 64'(bus.iss_payload), 64'h0000_0120_000C);
    cyc(); bus.iss_ready = 1;
    @(negedge clk); chk("b2b_ready", 64'(bus.dec_ready), 64'd1);
    cyc(); instr(1, 14, 0, 0, 0, 0, 0, 48'h0000_0140_000E);
    @(negedge clk); chk("b2b_second", 64'(bus.iss_waddr), 64'd13);
    cyc(); idle_in();
    @(negedge clk); chk("b2b_third", 64'(bus.iss_waddr), 64'd14);
    cyc();

    // Reset mid-stall clears slot and pending set; late writeback ignored.
    instr(0, 0, 13, 1, 0, 0, 0, 48'h0000_0DDD_000F);
    cyc(); idle_in();
    @(negedge clk); chk("rst_pre_stall", 64'(bus.iss_valid), 64'd0);
    cyc(); rst = 1;
    @(negedge clk); chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_iss_waddr", 64'(bus.iss_waddr), 64'd0);
    cyc(); rst = 0; bus.wb_valid = 1; bus.wb_addr = 13;
    cyc(); idle_in();
    instr(1, 12, 12, 1, 0, 0, 0, 48'h0000_0121_0010);
    cyc(); idle_in();
    @(negedge clk); chk("post_rst_no_hazard", 64'(bus.iss_valid), 64'd1);
    cyc();

`ifdef ISSUE_CTRL_PERF_EN
    rst = 1; cyc(); rst = 0;
    instr(1, 5, 0, 0, 0, 0, 0, 48'h0000_0005_0011);
    cyc(); instr(0, 0, 5, 1, 0, 0, 0, 48'h0000_0005_0012);
    cyc(); idle_in();
    cyc(); cyc(); cyc(); bus.wb_valid = 1; bus.wb_addr = 5;
    cyc(); idle_in();
    @(negedge clk); chk("perf_stall3", 64'(stall_cnt), 64'd3);
    chk("perf_issue2", 64'(issue_cnt), 64'd2);
    instr(1, 9, 0, 0, 0, 0, 0, 48'h0000_0009_0013);
    cyc(); instr(0, 0, 9, 1, 0, 0, 0, 48'h0000_0009_0014);
    cyc(); idle_in();
    cyc(); rst = 1;
    @(negedge clk); chk("perf_rst_stall", 64'(stall_cnt), 64'd0);
    chk("perf_rst_issue", 64'(issue_cnt), 64'd0);
    cyc(); rst = 0;
`endif

    repeat (3) cyc();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
